// File: rtl/alu_seq_pkg.sv
// Shared definitions for the alu operand sequencer: state encodings and alu op width.
package alu_seq_pkg;

  localparam int unsigned OpW = 2;

  typedef enum logic [1:0] {
    StA    = 2'd0,
    StB    = 2'd1,
    StExec = 2'd2,
    StOut  = 2'd3
  } seqStateE;

endpackage

// File: rtl/alu_seq.sv
// Operand sequencer feeding a combinational alu; captures and returns its result.
// Define ALU_SEQ_CHAIN_EN to add in_chain (one-beat transactions reusing the last result as A).
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned W  = 4,
  parameter int unsigned CW = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic [OpW-1:0] in_op,
`ifdef ALU_SEQ_CHAIN_EN
  input  logic           in_chain,
`endif
  output logic [W-1:0]   alu_inA,
  output logic [W-1:0]   alu_inB,
  output logic [OpW-1:0] alu_op,
  input  logic [W-1:0]   alu_ans,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [CW-1:0]  txn_count
);

  seqStateE       stateQ, stateD;
  logic [W-1:0]   aReg, aD;
  logic [W-1:0]   bReg, bD;
  logic [OpW-1:0] opReg, opD;
  logic [W-1:0]   outReg, outD;
  logic [CW-1:0]  cntReg, cntD;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= StA;
      aReg   <= '0;
      bReg   <= '0;
      opReg  <= '0;
      outReg <= '0;
      cntReg <= '0;
    end else begin
      stateQ <= stateD;
      aReg   <= aD;
      bReg   <= bD;
      opReg  <= opD;
      outReg <= outD;
      cntReg <= cntD;
    end
  end

  always_comb begin
    stateD = stateQ;
    aD     = aReg;
    bD     = bReg;
    opD    = opReg;
    outD   = outReg;
    cntD   = cntReg;
    unique case (stateQ)
      StA: begin
        if (in_valid) begin
`ifdef ALU_SEQ_CHAIN_EN
          // Chained beat: previous result becomes A, this beat's data is B.
          if (in_chain) begin
            aD     = outReg;
            bD     = in_data;
            opD    = in_op;
            stateD = StExec;
          end else
`endif
          begin
            aD     = in_data;
            opD    = in_op;
            stateD = StB;
          end
        end
      end
      StB: begin
        if (in_valid) begin
          bD     = in_data;
          stateD = StExec;
        end
      end
      StExec: begin
        outD   = alu_ans;
        stateD = StOut;
      end
      StOut: begin
        if (out_ready) begin
          cntD   = cntReg + CW'(1);
          stateD = StA;
        end
      end
      default: stateD = StA;
    endcase
  end

  assign in_ready  = (stateQ == StA) || (stateQ == StB);
  assign out_valid = (stateQ == StOut);
  assign out_data  = outReg;
  assign txn_count = cntReg;
  assign alu_inA   = aReg;
  assign alu_inB   = bReg;
  assign alu_op    = opReg;

endmodule
